// File: rtl/hmac_trailer_check.sv
// hmac_trailer_check: strips the HMAC trailer beat from each input packet,
// forwards the payload to m_axis and to the HMAC engine (m_hash) with tlast
// moved onto the last payload beat, compares the trailer against the engine
// digest and emits one status record per packet.
module hmac_trailer_check #(
  parameter int AXIS_TDATA_WIDTH = 512,
  parameter int ID_WIDTH         = 6,
  parameter int DIGEST_BITS      = 256
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic [ID_WIDTH-1:0]           s_axis_tid,
  input  logic                          s_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic [ID_WIDTH-1:0]           m_axis_tid,
  output logic                          m_axis_tlast,
  output logic                          m_hash_tvalid,
  input  logic                          m_hash_tready,
  output logic [AXIS_TDATA_WIDTH-1:0]   m_hash_tdata,
  output logic [AXIS_TDATA_WIDTH/8-1:0] m_hash_tkeep,
  output logic [ID_WIDTH-1:0]           m_hash_tid,
  output logic                          m_hash_tlast,
  input  logic                          s_hash_tvalid,
  output logic                          s_hash_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0]   s_hash_tdata,
  output logic                          sts_valid,
  input  logic                          sts_ready,
  output logic                          sts_pass,
  output logic                          sts_empty,
  output logic [ID_WIDTH-1:0]           sts_tid,
  output logic [15:0]                   sts_beats
);

  localparam int KW = AXIS_TDATA_WIDTH / 8;

  typedef enum logic [1:0] {RUN, WAIT_DIG, STATUS} state_t;

  state_t                      r_state;
  // H: pending beat, not yet known to be last payload or not
  logic                        r_h_valid;
  logic [AXIS_TDATA_WIDTH-1:0] r_h_data;
  logic [KW-1:0]               r_h_keep;
  logic [ID_WIDTH-1:0]         r_h_id;
  // O: classified output stage shared by m_axis and m_hash
  logic                        r_o_valid;
  logic [AXIS_TDATA_WIDTH-1:0] r_o_data;
  logic [KW-1:0]               r_o_keep;
  logic [ID_WIDTH-1:0]         r_o_id;
  logic                        r_o_last;
  logic                        r_sent_m;
  logic                        r_sent_h;
  // T: trailer digest and tid
  logic [DIGEST_BITS-1:0]      r_t_digest;
  logic [ID_WIDTH-1:0]         r_t_id;
  logic [15:0]                 r_beat_cnt;
  logic                        r_pass;
  logic                        r_empty;

  logic w_m_fire;
  logic w_h_fire;
  logic w_o_retiring;
  logic w_s_fire;
  logic w_dig_fire;
  logic w_unused;

  // Handshake decode and output drive, all from registers and ready inputs
  always_comb begin
    m_axis_tvalid = r_o_valid && !r_sent_m;
    m_hash_tvalid = r_o_valid && !r_sent_h;
    w_m_fire      = m_axis_tvalid && m_axis_tready;
    w_h_fire      = m_hash_tvalid && m_hash_tready;
    // O retires when each destination is either already done or finishing now
    w_o_retiring  = r_o_valid && (r_sent_m || w_m_fire) && (r_sent_h || w_h_fire);
    s_axis_tready = (r_state == RUN) && (!r_o_valid || w_o_retiring);
    s_hash_tready = (r_state == WAIT_DIG) && !r_o_valid;
    w_s_fire      = s_axis_tvalid && s_axis_tready;
    w_dig_fire    = s_hash_tvalid && s_hash_tready;
    m_axis_tdata  = r_o_data;
    m_axis_tkeep  = r_o_keep;
    m_axis_tid    = r_o_id;
    m_axis_tlast  = r_o_last;
    m_hash_tdata  = r_o_data;
    m_hash_tkeep  = r_o_keep;
    m_hash_tid    = r_o_id;
    m_hash_tlast  = r_o_last;
    sts_valid     = (r_state == STATUS);
    sts_pass      = r_pass;
    sts_empty     = r_empty;
    sts_tid       = r_t_id;
    sts_beats     = r_beat_cnt;
    w_unused      = ^s_hash_tdata[AXIS_TDATA_WIDTH-1:DIGEST_BITS];
  end

  // Datapath registers and packet FSM
  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      r_state    <= RUN;
      r_h_valid  <= 1'b0;
      r_h_data   <= '0;
      r_h_keep   <= '0;
      r_h_id     <= '0;
      r_o_valid  <= 1'b0;
      r_o_data   <= '0;
      r_o_keep   <= '0;
      r_o_id     <= '0;
      r_o_last   <= 1'b0;
      r_sent_m   <= 1'b0;
      r_sent_h   <= 1'b0;
      r_t_digest <= '0;
      r_t_id     <= '0;
      r_beat_cnt <= '0;
      r_pass     <= 1'b0;
      r_empty    <= 1'b0;
    end else begin
      if (r_o_valid) begin
        if (w_m_fire) r_sent_m <= 1'b1;
        if (w_h_fire) r_sent_h <= 1'b1;
        if (w_o_retiring) begin
          r_o_valid <= 1'b0;
          r_sent_m  <= 1'b0;
          r_sent_h  <= 1'b0;
        end
      end

      case (r_state)
        RUN: begin
          if (w_s_fire) begin
            // H is only classified once the following beat shows whether it was last
            if (r_h_valid) begin
              r_o_valid <= 1'b1;
              r_o_data  <= r_h_data;
              r_o_keep  <= r_h_keep;
              r_o_id    <= r_h_id;
              r_o_last  <= s_axis_tlast;
              r_sent_m  <= 1'b0;
              r_sent_h  <= 1'b0;
              if (r_beat_cnt != 16'hFFFF) r_beat_cnt <= r_beat_cnt + 16'd1;
            end
            if (!s_axis_tlast) begin
              r_h_valid <= 1'b1;
              r_h_data  <= s_axis_tdata;
              r_h_keep  <= s_axis_tkeep;
              r_h_id    <= s_axis_tid;
            end else begin
              r_h_valid  <= 1'b0;
              r_t_digest <= s_axis_tdata[DIGEST_BITS-1:0];
              r_t_id     <= s_axis_tid;
              if (r_h_valid) begin
                r_state <= WAIT_DIG;
              end else begin
                r_pass  <= 1'b0;
                r_empty <= 1'b1;
                r_state <= STATUS;
              end
            end
          end
        end
        WAIT_DIG: begin
          if (w_dig_fire) begin
            r_pass  <= (s_hash_tdata[DIGEST_BITS-1:0] == r_t_digest);
            r_empty <= 1'b0;
            r_state <= STATUS;
          end
        end
        STATUS: begin
          if (sts_ready) begin
            r_beat_cnt <= '0;
            r_state    <= RUN;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hmac_trailer_check.sv
// Directed testbench for hmac_trailer_check.
module tb_hmac_trailer_check;

  localparam int W   = 512;
  localparam int KW  = 64;
  localparam int IDW = 6;
  localparam int DB  = 256;

  logic           aclk;
  logic           areset;
  logic           s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [W-1:0]   s_axis_tdata;
  logic [KW-1:0]  s_axis_tkeep;
  logic [IDW-1:0] s_axis_tid;
  logic           m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [W-1:0]   m_axis_tdata;
  logic [KW-1:0]  m_axis_tkeep;
  logic [IDW-1:0] m_axis_tid;
  logic           m_hash_tvalid, m_hash_tready, m_hash_tlast;
  logic [W-1:0]   m_hash_tdata;
  logic [KW-1:0]  m_hash_tkeep;
  logic [IDW-1:0] m_hash_tid;
  logic           s_hash_tvalid, s_hash_tready;
  logic [W-1:0]   s_hash_tdata;
  logic           sts_valid, sts_ready, sts_pass, sts_empty;
  logic [IDW-1:0] sts_tid;
  logic [15:0]    sts_beats;

  typedef struct packed {
    logic [W-1:0]   d;
    logic [KW-1:0]  k;
    logic [IDW-1:0] id;
    logic           l;
  } beat_t;

  beat_t m_q[$];
  beat_t h_q[$];
  int    hash_xfers;
  int    checks;
  int    errors;

  logic [W-1:0] trl_a, trl_b, dig_a, dig_b;

  hmac_trailer_check #(
    .AXIS_TDATA_WIDTH(W),
    .ID_WIDTH(IDW),
    .DIGEST_BITS(DB)
  ) dut (
    .aclk(aclk), .areset(areset),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tid(s_axis_tid), .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tid(m_axis_tid), .m_axis_tlast(m_axis_tlast),
    .m_hash_tvalid(m_hash_tvalid), .m_hash_tready(m_hash_tready),
    .m_hash_tdata(m_hash_tdata), .m_hash_tkeep(m_hash_tkeep),
    .m_hash_tid(m_hash_tid), .m_hash_tlast(m_hash_tlast),
    .s_hash_tvalid(s_hash_tvalid), .s_hash_tready(s_hash_tready),
    .s_hash_tdata(s_hash_tdata),
    .sts_valid(sts_valid), .sts_ready(sts_ready), .sts_pass(sts_pass),
    .sts_empty(sts_empty), .sts_tid(sts_tid), .sts_beats(sts_beats)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Record handshakes half a cycle before the edge that completes them
  always @(negedge aclk) begin
    if (m_axis_tvalid && m_axis_tready)
      m_q.push_back(beat_t'({m_axis_tdata, m_axis_tkeep, m_axis_tid, m_axis_tlast}));
    if (m_hash_tvalid && m_hash_tready)
      h_q.push_back(beat_t'({m_hash_tdata, m_hash_tkeep, m_hash_tid, m_hash_tlast}));
    if (s_hash_tvalid && s_hash_tready) hash_xfers++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] pay(input int i);
    logic [7:0] b;
    b = 8'((i + 1) * 17);
    return {64{b}};
  endfunction

  function automatic logic [KW-1:0] pkeep(input int i, input int n);
    return (i == n - 1) ? 64'h0000_00FF_FFFF_FFFF : '1;
  endfunction

  task automatic send_beat(input logic [W-1:0] d, input logic [KW-1:0] k,
                           input logic [IDW-1:0] id, input logic l);
    bit done;
    done = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tid    = id;
    s_axis_tlast  = l;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge aclk);
      if (s_axis_tready) done = 1;
    end
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_timeout: s_axis_tready got 0 required 1 within 200 cycles");
    end
  endtask

  task automatic send_packet(input int n, input logic [IDW-1:0] id, input logic [W-1:0] trl);
    for (int i = 0; i < n; i++) send_beat(pay(i), pkeep(i, n), id, 1'b0);
    send_beat(trl, 64'h1, id, 1'b1);
  endtask

  task automatic send_digest(input logic [W-1:0] d);
    bit done;
    done = 0;
    s_hash_tvalid = 1'b1;
    s_hash_tdata  = d;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge aclk);
      if (s_hash_tready) done = 1;
    end
    @(posedge aclk);
    #1;
    s_hash_tvalid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL digest_timeout: s_hash_tready got 0 required 1 within 200 cycles");
    end
  endtask

  task automatic wait_status();
    bit done;
    done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge aclk);
      if (sts_valid) done = 1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL status_timeout: sts_valid got 0 required 1 within 200 cycles");
    end
  endtask

  task automatic ack_status();
    sts_ready = 1'b1;
    @(posedge aclk);
    #1;
    sts_ready = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    checks++;
    if ({m_axis_tvalid, m_hash_tvalid, sts_valid, s_hash_tready, sts_pass, sts_empty} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 000000",
               {m_axis_tvalid, m_hash_tvalid, sts_valid, s_hash_tready, sts_pass, sts_empty});
    end
    checks++;
    if (sts_beats !== 16'd0) begin
      errors++;
      $display("FAIL reset_beats: got %0d required 0", sts_beats);
    end
    areset = 1'b1;
    @(negedge aclk);
    checks++;
    if (s_axis_tready !== 1'b1) begin
      errors++;
      $display("FAIL reset_tready: got %b required 1", s_axis_tready);
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic test_basic_pass();
    m_q.delete();
    h_q.delete();
    send_packet(3, 6'd5, trl_a);
    send_digest(dig_a);
    checks++;
    if (sts_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_sts_latency: sts_valid got %b required 1", sts_valid);
    end
    wait_status();
    checks++;
    if ({sts_pass, sts_empty, sts_beats, sts_tid} !== {1'b1, 1'b0, 16'd3, 6'd5}) begin
      errors++;
      $display("FAIL basic_status: pass/empty/beats/tid got %b/%b/%0d/%0d required 1/0/3/5",
               sts_pass, sts_empty, sts_beats, sts_tid);
    end
    ack_status();
    checks++;
    if (m_q.size() != 3 || h_q.size() != 3) begin
      errors++;
      $display("FAIL basic_count: m/h beats got %0d/%0d required 3/3", m_q.size(), h_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (m_q[i] !== beat_t'({pay(i), pkeep(i, 3), 6'd5, (i == 2)})) begin
          errors++;
          $display("FAIL basic_m_beat%0d: got tlast=%b keep=%h id=%0d data[7:0]=%h required tlast=%b keep=%h id=5 data[7:0]=%h",
                   i, m_q[i].l, m_q[i].k, m_q[i].id, m_q[i].d[7:0], (i == 2), pkeep(i, 3), pay(i) & 512'hFF);
        end
        checks++;
        if (h_q[i] !== beat_t'({pay(i), pkeep(i, 3), 6'd5, (i == 2)})) begin
          errors++;
          $display("FAIL basic_h_beat%0d: got tlast=%b keep=%h id=%0d data[7:0]=%h",
                   i, h_q[i].l, h_q[i].k, h_q[i].id, h_q[i].d[7:0]);
        end
      end
    end
  endtask

  task automatic test_mismatch();
    logic [W-1:0] bad;
    m_q.delete();
    h_q.delete();
    bad = dig_a ^ 512'h1;
    send_packet(3, 6'd5, trl_a);
    send_digest(bad);
    wait_status();
    checks++;
    if ({sts_pass, sts_empty, sts_beats} !== {1'b0, 1'b0, 16'd3}) begin
      errors++;
      $display("FAIL mismatch_status: pass/empty/beats got %b/%b/%0d required 0/0/3",
               sts_pass, sts_empty, sts_beats);
    end
    ack_status();
    checks++;
    if (m_q.size() != 3 || h_q.size() != 3 || m_q[2].l !== 1'b1 || m_q[2].d !== pay(2)) begin
      errors++;
      $display("FAIL mismatch_payload: m/h beats got %0d/%0d required 3/3 with last on 0x33",
               m_q.size(), h_q.size());
    end
  endtask

  task automatic test_trailer_only();
    int x0;
    m_q.delete();
    h_q.delete();
    x0 = hash_xfers;
    send_beat(trl_a, 64'h1, 6'd9, 1'b1);
    checks++;
    if (sts_valid !== 1'b1) begin
      errors++;
      $display("FAIL empty_sts_latency: sts_valid got %b required 1", sts_valid);
    end
    @(negedge aclk);
    checks++;
    if ({sts_pass, sts_empty, sts_beats, sts_tid, s_hash_tready} !== {1'b0, 1'b1, 16'd0, 6'd9, 1'b0}) begin
      errors++;
      $display("FAIL empty_status: pass/empty/beats/tid/hready got %b/%b/%0d/%0d/%b required 0/1/0/9/0",
               sts_pass, sts_empty, sts_beats, sts_tid, s_hash_tready);
    end
    ack_status();
    repeat (2) @(posedge aclk);
    #1;
    checks++;
    if (m_q.size() != 0 || h_q.size() != 0 || hash_xfers != x0) begin
      errors++;
      $display("FAIL empty_no_traffic: m/h/digest transfers got %0d/%0d/%0d required 0/0/0",
               m_q.size(), h_q.size(), hash_xfers - x0);
    end
  endtask

  task automatic test_split_backpressure();
    int  m_sz, h_sz;
    bit  saw_stall;
    m_q.delete();
    h_q.delete();
    m_hash_tready = 1'b0;
    saw_stall = 0;
    fork
      send_packet(3, 6'd3, trl_a);
      begin
        for (int c = 0; c < 10; c++) begin
          @(negedge aclk);
          if (s_axis_tvalid && !s_axis_tready && m_hash_tvalid && !m_axis_tvalid) saw_stall = 1;
        end
        @(posedge aclk);
        #1;
        m_sz = m_q.size();
        h_sz = h_q.size();
        m_hash_tready = 1'b1;
      end
    join
    checks++;
    if (!saw_stall) begin
      errors++;
      $display("FAIL split_stall: s_axis_tready drop with O held got 0 required 1");
    end
    checks++;
    if (m_sz != 1 || h_sz != 0) begin
      errors++;
      $display("FAIL split_once: m/h beats during stall got %0d/%0d required 1/0", m_sz, h_sz);
    end
    send_digest(dig_a);
    wait_status();
    checks++;
    if ({sts_pass, sts_beats, sts_tid} !== {1'b1, 16'd3, 6'd3}) begin
      errors++;
      $display("FAIL split_status: pass/beats/tid got %b/%0d/%0d required 1/3/3", sts_pass, sts_beats, sts_tid);
    end
    ack_status();
    checks++;
    if (m_q.size() != 3 || h_q.size() != 3) begin
      errors++;
      $display("FAIL split_count: m/h beats got %0d/%0d required 3/3", m_q.size(), h_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (m_q[i].d !== pay(i) || h_q[i].d !== pay(i) || h_q[i].l !== (i == 2)) begin
          errors++;
          $display("FAIL split_beat%0d: m/h data[7:0] got %h/%h hlast %b required %h/%h last %b",
                   i, m_q[i].d[7:0], h_q[i].d[7:0], h_q[i].l, 8'((i + 1) * 17), 8'((i + 1) * 17), (i == 2));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit bad;
    m_q.delete();
    h_q.delete();
    send_packet(2, 6'd1, trl_a);
    send_digest(dig_a);
    wait_status();
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      if (s_axis_tready !== 1'b0 || sts_valid !== 1'b1 || sts_beats !== 16'd2) bad = 1;
      @(negedge aclk);
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL b2b_hold: s_axis_tready/sts_valid got %b/%b required 0/1 while sts_ready=0",
               s_axis_tready, sts_valid);
    end
    ack_status();
    send_packet(2, 6'd2, trl_b);
    send_digest(dig_b);
    wait_status();
    checks++;
    if ({sts_pass, sts_empty, sts_beats, sts_tid} !== {1'b1, 1'b0, 16'd2, 6'd2}) begin
      errors++;
      $display("FAIL b2b_second: pass/empty/beats/tid got %b/%b/%0d/%0d required 1/0/2/2",
               sts_pass, sts_empty, sts_beats, sts_tid);
    end
    ack_status();
    checks++;
    if (m_q.size() != 4 || h_q.size() != 4) begin
      errors++;
      $display("FAIL b2b_count: m/h beats got %0d/%0d required 4/4", m_q.size(), h_q.size());
    end
  endtask

  task automatic test_mid_reset();
    bit saw_sts;
    m_axis_tready = 1'b0;
    send_beat(pay(0), '1, 6'd7, 1'b0);
    send_beat(pay(1), '1, 6'd7, 1'b0);
    checks++;
    if (m_axis_tvalid !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre: m_axis_tvalid got %b required 1", m_axis_tvalid);
    end
    #2;
    areset = 1'b0;
    #1;
    checks++;
    if ({m_axis_tvalid, m_hash_tvalid, sts_valid, s_hash_tready} !== 4'b0) begin
      errors++;
      $display("FAIL midrst_valids: got %b required 0000",
               {m_axis_tvalid, m_hash_tvalid, sts_valid, s_hash_tready});
    end
    @(posedge aclk);
    #1;
    areset = 1'b1;
    m_axis_tready = 1'b1;
    m_q.delete();
    h_q.delete();
    saw_sts = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge aclk);
      if (sts_valid) saw_sts = 1;
    end
    checks++;
    if (saw_sts) begin
      errors++;
      $display("FAIL midrst_no_status: sts_valid got 1 required 0");
    end
    @(posedge aclk);
    #1;
    send_packet(3, 6'd4, trl_b);
    send_digest(dig_b);
    wait_status();
    checks++;
    if ({sts_pass, sts_empty, sts_beats, sts_tid} !== {1'b1, 1'b0, 16'd3, 6'd4}) begin
      errors++;
      $display("FAIL midrst_next: pass/empty/beats/tid got %b/%b/%0d/%0d required 1/0/3/4",
               sts_pass, sts_empty, sts_beats, sts_tid);
    end
    ack_status();
    checks++;
    if (m_q.size() != 3 || h_q.size() != 3) begin
      errors++;
      $display("FAIL midrst_count: m/h beats got %0d/%0d required 3/3", m_q.size(), h_q.size());
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    hash_xfers = 0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tid    = '0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;
    m_hash_tready = 1'b1;
    s_hash_tvalid = 1'b0;
    s_hash_tdata  = '0;
    sts_ready     = 1'b0;
    // Trailers carry junk above the digest field; engine results carry zeros there
    trl_a = {256'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5,
             256'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0};
    dig_a = {256'h0,
             256'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0};
    trl_b = {256'h5A5A_0000_FFFF_1234_5A5A_0000_FFFF_1234_5A5A_0000_FFFF_1234_5A5A_0000_FFFF_1234,
             256'hCAFE_BABE_DEAD_BEEF_1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA_BBBB_CCCC};
    dig_b = {256'h0,
             256'hCAFE_BABE_DEAD_BEEF_1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA_BBBB_CCCC};
    test_reset();
    test_basic_pass();
    test_mismatch();
    test_trailer_only();
    test_split_backpressure();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
